// File: rtl/count_sweep_ctrl_if.sv
// Host and counter-side signals of the sweep sequencer.
// The master side is the host/counter environment; the slave side is the controller.
interface count_sweep_ctrl_if #(
  parameter int WIDTH   = 16,
  parameter int SWEEP_W = 8
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   lo_lim;
  logic [WIDTH-1:0]   hi_lim;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [WIDTH-1:0]   cnt_value;
  logic               cnt_up_down;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [SWEEP_W-1:0] sweep_cnt;

  modport master (
    output start, abort, lo_lim, hi_lim, num_sweeps, cnt_value,
    input  cnt_up_down, busy, done, cfg_err, sweep_cnt
  );

  modport slave (
    input  start, abort, lo_lim, hi_lim, num_sweeps, cnt_value,
    output cnt_up_down, busy, done, cfg_err, sweep_cnt
  );
endinterface

// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for a free-running up/down counter: bounces count_out between
// latched limits a programmed number of times, then parks and dithers in IDLE.
module count_sweep_ctrl #(
  parameter int WIDTH   = 16,
  parameter int SWEEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  count_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEEK, UP, DOWN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [SWEEP_W-1:0] num_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic               tgl;
  logic               busy_q;
  logic               done_q;
  logic               cfg_err_q;

  logic               cfg_ok;
  logic [SWEEP_W-1:0] sweep_nxt;
  logic               dir;

  assign cfg_ok    = (bus.lo_lim < bus.hi_lim) && (bus.num_sweeps != '0);
  assign sweep_nxt = sweep_q + 1'b1;

  // Counter samples dir on the same edge as the state update, so dir must be
  // combinational from the current state and count to avoid overshooting a limit.
  always_comb begin
    dir = 1'b0;
    case (state)
      IDLE:    dir = tgl;
      SEEK:    dir = (bus.cnt_value > lo_q);
      UP:      dir = (bus.cnt_value == hi_q);
      DOWN:    dir = (bus.cnt_value != lo_q);
      default: dir = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      num_q     <= '0;
      sweep_q   <= '0;
      tgl       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (busy_q && bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        tgl    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tgl <= ~tgl;
            if (bus.start && !bus.abort) begin
              if (cfg_ok) begin
                lo_q    <= bus.lo_lim;
                hi_q    <= bus.hi_lim;
                num_q   <= bus.num_sweeps;
                sweep_q <= '0;
                busy_q  <= 1'b1;
                state   <= SEEK;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          SEEK: if (bus.cnt_value == lo_q) state <= UP;
          UP:   if (bus.cnt_value == hi_q) state <= DOWN;
          DOWN: begin
            if (bus.cnt_value == lo_q) begin
              sweep_q <= sweep_nxt;
              if (sweep_nxt == num_q) begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= UP;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            tgl   <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cnt_up_down = dir;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.sweep_cnt   = sweep_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Closed-loop bench: a behavioural up/down counter follows cnt_up_down, and an
// expected count trajectory is queued per run and compared cycle by cycle.
module tb_count_sweep_ctrl;
  localparam int W = 16;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  count_sweep_ctrl_if #(.WIDTH(W), .SWEEP_W(S)) bus ();
  count_sweep_ctrl #(.WIDTH(W), .SWEEP_W(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [W-1:0] cnt;
  logic         pre_en;
  logic [W-1:0] pre_val;

  always @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (pre_en) cnt <= pre_val;
    else             cnt <= bus.cnt_up_down ? cnt - 1'b1 : cnt + 1'b1;
  end
  assign bus.cnt_value = cnt;

  typedef struct {
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic [S-1:0] sweep;
    int           phase;   // 0 seek, 1 up, 2 down, 3 done
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic push(input logic [W-1:0] c, input int ph, input logic [S-1:0] sw);
    exp_t e;
    e.cnt = c; e.busy = (ph != 3); e.done = (ph == 3); e.sweep = sw; e.phase = ph;
    sb.push_back(e);
  endtask

  // Expected trajectory: walk to lo, then n round trips lo->hi->lo, then one DONE cycle.
  task automatic gen(input logic [W-1:0] c1, input logic [W-1:0] lo, input logic [W-1:0] hi,
                     input int n);
    logic [W-1:0] c;
    int lo_i, hi_i;
    lo_i = int'(lo); hi_i = int'(hi);
    c = c1;
    while (c != lo) begin
      push(c, 0, '0);
      c = (c > lo) ? c - 1'b1 : c + 1'b1;
    end
    push(lo, 0, '0);
    for (int s = 0; s < n; s++) begin
      for (int v = lo_i + 1; v <= hi_i; v++) push(W'(v), 1, S'(s));
      for (int v = hi_i - 1; v >= lo_i; v--) push(W'(v), 2, S'(s));
    end
    push(lo + 1'b1, 3, S'(n));
  endtask

  task automatic start_cmd(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [S-1:0] n);
    @(negedge clk);
    bus.start = 1'b1; bus.lo_lim = lo; bus.hi_lim = hi; bus.num_sweeps = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_abort(input logic [S-1:0] held);
    logic [W-1:0] a, b, c;
    logic d0, d1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.sweep_cnt} !== {1'b0, 1'b0, held}) begin
      bad++;
      $display("FAIL abort_state: busy/done/sweep got %b/%b/%0d want 0/0/%0d",
               bus.busy, bus.done, bus.sweep_cnt, held);
    end
    a = cnt; d0 = bus.cnt_up_down;
    @(negedge clk);
    b = cnt; d1 = bus.cnt_up_down;
    @(negedge clk);
    c = cnt;
    total++;
    if (c !== a || b === a || d1 === d0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_dither: cnt %0h,%0h,%0h dir %b,%b done %b want a,a+-1,a toggling done 0",
               a, b, c, d0, d1, bus.done);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cfg_err, bus.sweep_cnt, bus.cnt_up_down, cnt} !== '0) begin
      bad++;
      $display("FAIL reset_mid_down: busy %b done %b err %b sweep %0d dir %b cnt %0h want all 0",
               bus.busy, bus.done, bus.cfg_err, bus.sweep_cnt, bus.cnt_up_down, cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ev_kind: 0 none, 1 inject start with new limits, 2 abort, 3 reset
  task automatic drain(input int ev_kind, input int ev_ph, input logic [W-1:0] ev_cnt,
                       input logic [S-1:0] ev_sw);
    exp_t e;
    logic fired;
    fired = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (cnt !== e.cnt) begin
        bad++;
        $display("FAIL traj_cnt: got %0h want %0h (phase %0d)", cnt, e.cnt, e.phase);
      end
      total++;
      if ({bus.busy, bus.done, bus.cfg_err, bus.sweep_cnt} !== {e.busy, e.done, 1'b0, e.sweep}) begin
        bad++;
        $display("FAIL traj_flags: busy/done/err/sweep got %b/%b/%b/%0d want %b/%b/0/%0d at cnt %0h",
                 bus.busy, bus.done, bus.cfg_err, bus.sweep_cnt, e.busy, e.done, e.sweep, e.cnt);
      end
      bus.start = 1'b0;
      if (!fired && ev_kind != 0 && e.phase == ev_ph && e.cnt == ev_cnt && e.sweep == ev_sw) begin
        fired = 1'b1;
        case (ev_kind)
          1: begin
            bus.start = 1'b1; bus.lo_lim = 16'd10; bus.hi_lim = 16'd20; bus.num_sweeps = 8'd1;
          end
          2: begin sb.delete(); do_abort(e.sweep); end
          3: begin sb.delete(); do_reset(); end
          default: ;
        endcase
      end
      if (sb.size() > 0) @(negedge clk);
    end
    total++;
    if (ev_kind != 0 && !fired) begin
      bad++;
      $display("FAIL event_reached: got 0 want 1 (kind %0d)", ev_kind);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({bus.busy, bus.done, bus.cfg_err, bus.sweep_cnt, bus.cnt_up_down} !== '0) begin
      bad++;
      $display("FAIL reset_vals: busy %b done %b err %b sweep %0d dir %b want 0",
               bus.busy, bus.done, bus.cfg_err, bus.sweep_cnt, bus.cnt_up_down);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_cnt0();
    for (int i = 0; i < 8 && cnt != 0; i++) @(negedge clk);
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("FAIL wait_cnt0: got %0h want 0", cnt);
    end
  endtask

  task automatic run(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [S-1:0] n,
                     input int ev_kind, input int ev_ph, input logic [W-1:0] ev_cnt,
                     input logic [S-1:0] ev_sw);
    start_cmd(lo, hi, n);
    gen(cnt, lo, hi, int'(n));
    drain(ev_kind, ev_ph, ev_cnt, ev_sw);
  endtask

  task automatic test_basic();
    @(negedge clk);
    wait_cnt0();
    run(16'd2, 16'd5, 8'd2, 0, 0, '0, '0);
  endtask

  task automatic check_reject(input logic [W-1:0] lo, input logic [W-1:0] hi,
                              input logic [S-1:0] n, input logic [S-1:0] held);
    start_cmd(lo, hi, n);
    total++;
    if ({bus.cfg_err, bus.busy, bus.sweep_cnt} !== {1'b1, 1'b0, held}) begin
      bad++;
      $display("FAIL cfg_err_pulse: err/busy/sweep got %b/%b/%0d want 1/0/%0d",
               bus.cfg_err, bus.busy, bus.sweep_cnt, held);
    end
    @(negedge clk);
    total++;
    if ({bus.cfg_err, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL cfg_err_width: err/busy got %b/%b want 0/0", bus.cfg_err, bus.busy);
    end
  endtask

  task automatic test_cfg_err();
    check_reject(16'd5, 16'd5, 8'd1, 8'd2);
    check_reject(16'd1, 16'd9, 8'd0, 8'd2);
    check_reject(16'd9, 16'd3, 8'd1, 8'd2);
  endtask

  task automatic test_seek_down();
    @(negedge clk);
    pre_en = 1'b1; pre_val = 16'h0100;
    @(negedge clk);
    pre_en = 1'b0;
    run(16'h0010, 16'h0020, 8'd1, 0, 0, '0, '0);
  endtask

  task automatic test_abort();
    run(16'd2, 16'd5, 8'd3, 2, 1, 16'd4, 8'd1);
  endtask

  task automatic test_idle_abort_start();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    bus.lo_lim = 16'd1; bus.hi_lim = 16'd4; bus.num_sweeps = 8'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    total++;
    if ({bus.busy, bus.cfg_err, bus.sweep_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL idle_abort_start: busy/err/sweep got %b/%b/%0d want 0/0/1",
               bus.busy, bus.cfg_err, bus.sweep_cnt);
    end
  endtask

  task automatic test_back_to_back_start();
    run(16'd2, 16'd5, 8'd2, 1, 1, 16'd4, 8'd0);
  endtask

  task automatic test_reset_mid_down();
    run(16'd3, 16'd7, 8'd2, 3, 2, 16'd4, 8'd0);
    run(16'd1, 16'd3, 8'd1, 0, 0, '0, '0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.lo_lim = '0; bus.hi_lim = '0; bus.num_sweeps = '0;
    pre_en = 1'b0; pre_val = '0;
    test_reset();
    test_basic();
    test_cfg_err();
    test_seek_down();
    test_abort();
    test_idle_abort_start();
    test_back_to_back_start();
    test_reset_mid_down();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
